// File: rtl/bg_frame_controller.sv
// -----------------------------------------------------------------------------
// bg_frame_controller
//
// Sequences one tile of pixels through the pixel processing element (PE):
// latches the host tile, runs the PE sum pass, turns the per-channel sums into
// the expected background colour, runs the background-removal pass and hands
// the processed tile back to the host. A per-pass watchdog turns a PE that
// never reports done into an ERROR state the host can clear.
//
// Ports
//   Clk, Reset                          clock (rising edge), async active-high reset
//   Start, Host_Ack                     host request / acknowledge of Done or Err
//   red_in, green_in, blue_in           host tile, pixel k in bits [8k+7:8k]
//   threshold, desired_bg_r/g/b         pass-through PE configuration
//   pe_red_in, pe_green_in, pe_blue_in  latched tile driven to the PE
//   pe_start_sum, pe_start_bg, pe_ack   PE control pulses
//   pe_sum_done, pe_bg_done             PE pass-complete levels
//   pe_red_sum, pe_green_sum, pe_blue_sum  PE per-channel sums
//   pe_red_out, pe_green_out, pe_blue_out  PE result tile
//   red_exp, green_exp, blue_exp        expected background colour for the PE
//   red_out, green_out, blue_out        result tile to the host
//   Busy, Done, Err                     host status
//
// PE handshake: a start pulse is high for exactly one cycle (SUM_REQ or
// BG_REQ). The matching done level is only honoured while waiting for that
// pass (SUM_WAIT / BG_WAIT); anywhere else it is ignored. The controller
// answers every accepted done with a one-cycle pe_ack (AVG, CAPTURE), and
// holds pe_ack high in ERROR to return the PE to idle. Starts and acks come
// from distinct states, so they can never coincide.
// -----------------------------------------------------------------------------
module bg_frame_controller #(
  parameter int LOG2_PIXELS = 2,
  parameter int SUM_W       = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic                           Host_Ack,
  input  logic [(8<<LOG2_PIXELS)-1:0]    red_in,
  input  logic [(8<<LOG2_PIXELS)-1:0]    green_in,
  input  logic [(8<<LOG2_PIXELS)-1:0]    blue_in,
  input  logic [7:0]                     threshold,
  input  logic [7:0]                     desired_bg_r,
  input  logic [7:0]                     desired_bg_g,
  input  logic [7:0]                     desired_bg_b,
  output logic [(8<<LOG2_PIXELS)-1:0]    pe_red_in,
  output logic [(8<<LOG2_PIXELS)-1:0]    pe_green_in,
  output logic [(8<<LOG2_PIXELS)-1:0]    pe_blue_in,
  output logic                           pe_start_sum,
  output logic                           pe_start_bg,
  output logic                           pe_ack,
  input  logic                           pe_sum_done,
  input  logic                           pe_bg_done,
  input  logic [SUM_W-1:0]               pe_red_sum,
  input  logic [SUM_W-1:0]               pe_green_sum,
  input  logic [SUM_W-1:0]               pe_blue_sum,
  input  logic [(8<<LOG2_PIXELS)-1:0]    pe_red_out,
  input  logic [(8<<LOG2_PIXELS)-1:0]    pe_green_out,
  input  logic [(8<<LOG2_PIXELS)-1:0]    pe_blue_out,
  output logic [7:0]                     red_exp,
  output logic [7:0]                     green_exp,
  output logic [7:0]                     blue_exp,
  output logic [(8<<LOG2_PIXELS)-1:0]    red_out,
  output logic [(8<<LOG2_PIXELS)-1:0]    green_out,
  output logic [(8<<LOG2_PIXELS)-1:0]    blue_out,
  output logic                           Busy,
  output logic                           Done,
  output logic                           Err
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [9:0] {
    IDLE     = 10'b00_0000_0001,
    LOAD     = 10'b00_0000_0010,
    SUM_REQ  = 10'b00_0000_0100,
    SUM_WAIT = 10'b00_0000_1000,
    AVG      = 10'b00_0001_0000,
    BG_REQ   = 10'b00_0010_0000,
    BG_WAIT  = 10'b00_0100_0000,
    CAPTURE  = 10'b00_1000_0000,
    DONE     = 10'b01_0000_0000,
    ERROR    = 10'b10_0000_0000
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q;

  // The PE configuration only passes by this block; the sums are used through
  // an 8-bit window, so their remaining bits are collected here.
  logic unused_inputs;
  assign unused_inputs = ^{threshold, desired_bg_r, desired_bg_g, desired_bg_b,
                           pe_red_sum, pe_green_sum, pe_blue_sum};

  // Next state and the PE control pulses, all decoded from the current state.
  always_comb begin
    state_d      = state_q;
    pe_start_sum = 1'b0;
    pe_start_bg  = 1'b0;
    pe_ack       = 1'b0;
    case (state_q)
      IDLE:     if (Start) state_d = LOAD;
      LOAD:     state_d = SUM_REQ;
      SUM_REQ: begin
        pe_start_sum = 1'b1;
        state_d      = SUM_WAIT;
      end
      // Done is checked before the watchdog so a late done still succeeds.
      SUM_WAIT: begin
        if (pe_sum_done)         state_d = AVG;
        else if (wd_q == WD_MAX) state_d = ERROR;
      end
      AVG: begin
        pe_ack  = 1'b1;
        state_d = BG_REQ;
      end
      BG_REQ: begin
        pe_start_bg = 1'b1;
        state_d     = BG_WAIT;
      end
      BG_WAIT: begin
        if (pe_bg_done)          state_d = CAPTURE;
        else if (wd_q == WD_MAX) state_d = ERROR;
      end
      CAPTURE: begin
        pe_ack  = 1'b1;
        state_d = DONE;
      end
      DONE:     if (Host_Ack) state_d = IDLE;
      ERROR: begin
        pe_ack = 1'b1;
        if (Host_Ack) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Err  = (state_q == ERROR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      pe_red_in   <= '0;
      pe_green_in <= '0;
      pe_blue_in  <= '0;
      red_exp     <= '0;
      green_exp   <= '0;
      blue_exp    <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && Start) begin
        pe_red_in   <= red_in;
        pe_green_in <= green_in;
        pe_blue_in  <= blue_in;
      end

      // Watchdog: cleared on each start pulse, counts idle wait cycles.
      if (state_q == SUM_REQ || state_q == BG_REQ) begin
        wd_q <= '0;
      end else if (((state_q == SUM_WAIT && !pe_sum_done) ||
                    (state_q == BG_WAIT && !pe_bg_done)) && wd_q != WD_MAX) begin
        wd_q <= wd_q + 1'b1;
      end

      // Average = sum >> LOG2_PIXELS truncated to 8 bits, i.e. the 8-bit
      // window starting at bit LOG2_PIXELS. The PE sum bound makes it exact.
      if (state_q == SUM_WAIT && pe_sum_done) begin
        red_exp   <= pe_red_sum[LOG2_PIXELS +: 8];
        green_exp <= pe_green_sum[LOG2_PIXELS +: 8];
        blue_exp  <= pe_blue_sum[LOG2_PIXELS +: 8];
      end

      if (state_q == CAPTURE) begin
        red_out   <= pe_red_out;
        green_out <= pe_green_out;
        blue_out  <= pe_blue_out;
      end
    end
  end

endmodule

// File: tb/tb_bg_frame_controller.sv
// -----------------------------------------------------------------------------
// tb_bg_frame_controller
//
// Directed bench for bg_frame_controller with the default parameters
// (4 pixels, 16-bit sums, TIMEOUT 255). A small behavioural PE answers start
// pulses after a programmable number of cycles (0 = never answers). Each
// table record carries the host tile, the PE sums/result tile and latencies,
// and the hand-computed expected colour, output tile and busy-cycle latency.
// -----------------------------------------------------------------------------
module tb_bg_frame_controller;

  localparam int TW = 32;

  logic          Clk, Reset, Start, Host_Ack;
  logic [TW-1:0] red_in, green_in, blue_in;
  logic [7:0]    threshold, desired_bg_r, desired_bg_g, desired_bg_b;
  logic [TW-1:0] pe_red_in, pe_green_in, pe_blue_in;
  logic          pe_start_sum, pe_start_bg, pe_ack;
  logic          pe_sum_done, pe_bg_done;
  logic [15:0]   pe_red_sum, pe_green_sum, pe_blue_sum;
  logic [TW-1:0] pe_red_out, pe_green_out, pe_blue_out;
  logic [7:0]    red_exp, green_exp, blue_exp;
  logic [TW-1:0] red_out, green_out, blue_out;
  logic          Busy, Done, Err;

  bg_frame_controller dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Host_Ack(Host_Ack),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .threshold(threshold), .desired_bg_r(desired_bg_r),
    .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
    .pe_red_in(pe_red_in), .pe_green_in(pe_green_in), .pe_blue_in(pe_blue_in),
    .pe_start_sum(pe_start_sum), .pe_start_bg(pe_start_bg), .pe_ack(pe_ack),
    .pe_sum_done(pe_sum_done), .pe_bg_done(pe_bg_done),
    .pe_red_sum(pe_red_sum), .pe_green_sum(pe_green_sum), .pe_blue_sum(pe_blue_sum),
    .pe_red_out(pe_red_out), .pe_green_out(pe_green_out), .pe_blue_out(pe_blue_out),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- PE model ----------------
  // Done rises so that it is sampled in the lat-th cycle after the start pulse.
  int s_lat, b_lat;
  int sum_left, bg_left;

  always @(negedge Clk) begin
    if (Reset) begin
      pe_sum_done = 1'b0; pe_bg_done = 1'b0; sum_left = 0; bg_left = 0;
    end else begin
      if (pe_ack) begin
        pe_sum_done = 1'b0; pe_bg_done = 1'b0; sum_left = 0; bg_left = 0;
      end
      if (pe_start_sum && s_lat > 0) sum_left = s_lat;
      else if (sum_left > 0) begin
        sum_left--;
        if (sum_left == 0) pe_sum_done = 1'b1;
      end
      if (pe_start_bg && b_lat > 0) bg_left = b_lat;
      else if (bg_left > 0) begin
        bg_left--;
        if (bg_left == 0) pe_bg_done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [TW-1:0] r, g, b;        // host tile
    logic [15:0]   rs, gs, bs;     // PE sums
    int            s_lat, b_lat;   // PE latencies, 0 = never done
    logic [TW-1:0] pr, pg, pb;     // PE result tile
    logic [7:0]    er, eg, eb;     // expected colour after the frame
    logic [TW-1:0] xr, xg, xb;     // expected host output tile after the frame
    int            lat;            // busy cycles before Done/Err
    bit            err;            // frame ends in ERROR
    bit            noisy;          // toggle Start while busy
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  task automatic do_frame(input vec_t v, input bit do_ack);
    int busy_cnt, n_ss, n_sb, n_ack, n_ovl, guard;
    busy_cnt = 0; n_ss = 0; n_sb = 0; n_ack = 0; n_ovl = 0; guard = 0;
    red_in = v.r; green_in = v.g; blue_in = v.b;
    pe_red_sum = v.rs; pe_green_sum = v.gs; pe_blue_sum = v.bs;
    pe_red_out = v.pr; pe_green_out = v.pg; pe_blue_out = v.pb;
    s_lat = v.s_lat; b_lat = v.b_lat;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    // The tile must have been latched; change the host inputs under it.
    red_in = $urandom; green_in = $urandom; blue_in = $urandom;
    while (!(Done || Err) && guard < 600) begin
      if (Busy) busy_cnt++;
      if (pe_start_sum) n_ss++;
      if (pe_start_bg) n_sb++;
      if (pe_ack) n_ack++;
      if ((pe_start_sum && pe_start_bg) || (pe_ack && (pe_start_sum || pe_start_bg))) n_ovl++;
      if (v.noisy) Start = 1'($urandom_range(0, 1));
      @(negedge Clk);
      guard++;
    end
    Start = 1'b0;
    chk("frame_ended", 64'(Done || Err), 64'(1));
    chk("err_flag", 64'(Err), 64'(v.err));
    chk("done_flag", 64'(Done), 64'(!v.err));
    chk("latency", 64'(busy_cnt), 64'(v.lat));
    chk("start_sum_count", 64'(n_ss), 64'(1));
    chk("start_bg_count", 64'(n_sb), 64'((v.s_lat > 0) ? 1 : 0));
    chk("ack_count", 64'(n_ack), 64'(v.err ? ((v.s_lat > 0) ? 1 : 0) : 2));
    chk("pulse_overlap", 64'(n_ovl), 64'(0));
    chk("red_exp", 64'(red_exp), 64'(v.er));
    chk("green_exp", 64'(green_exp), 64'(v.eg));
    chk("blue_exp", 64'(blue_exp), 64'(v.eb));
    chk("red_out", 64'(red_out), 64'(v.xr));
    chk("green_out", 64'(green_out), 64'(v.xg));
    chk("blue_out", 64'(blue_out), 64'(v.xb));
    chk("pe_red_in", 64'(pe_red_in), 64'(v.r));
    chk("pe_blue_in", 64'(pe_blue_in), 64'(v.b));
    if (v.err) begin
      chk("err_pe_ack", 64'(pe_ack), 64'(1));
      @(negedge Clk);
      chk("err_held", 64'({Err, pe_ack}), 64'(2'b11));
    end else begin
      @(negedge Clk);
      chk("done_held", 64'({Done, red_out}), {31'd0, 1'b1, v.xr});
    end
    if (do_ack) begin
      Host_Ack = 1'b1;
      @(negedge Clk);
      Host_Ack = 1'b0;
      chk("idle_after_ack", 64'({Busy, Done, Err}), 64'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard, n_ss;
    Reset = 1'b1; Start = 1'b0; Host_Ack = 1'b0;
    red_in = '0; green_in = '0; blue_in = '0;
    threshold = 8'd16; desired_bg_r = 8'd1; desired_bg_g = 8'd2; desired_bg_b = 8'd3;
    pe_red_sum = '0; pe_green_sum = '0; pe_blue_sum = '0;
    pe_red_out = '0; pe_green_out = '0; pe_blue_out = '0;
    pe_sum_done = 1'b0; pe_bg_done = 1'b0; s_lat = 0; b_lat = 0;
    sum_left = 0; bg_left = 0;

    // r g b | rs gs bs | s b | pr pg pb | er eg eb | xr xg xb | lat err noisy
    vecs[0] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 16'd10, 16'd26, 16'd42, 0, 1,
                32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 8'd0, 8'd0, 8'd0,
                32'h0, 32'h0, 32'h0, 258, 1'b1, 1'b0};
    vecs[1] = '{32'h281E140A, 32'h0, 32'h0, 16'd100, 16'd0, 16'd0, 3, 4,
                32'h11223344, 32'h55667788, 32'h99AABBCC, 8'd25, 8'd0, 8'd0,
                32'h11223344, 32'h55667788, 32'h99AABBCC, 12, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h03FC, 16'h03FC, 16'h03FC, 1, 1,
                32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 8'hFF, 8'hFF, 8'hFF,
                32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 7, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 16'h03FF, 16'h03FD, 16'h0003, 2, 5,
                32'h01020304, 32'hA0B0C0D0, 32'hFFFFFFFF, 8'hFF, 8'hFF, 8'h00,
                32'h01020304, 32'hA0B0C0D0, 32'hFFFFFFFF, 12, 1'b0, 1'b0};
    vecs[4] = '{32'h01010203, 32'h42404142, 32'h40403F3F, 16'h0007, 16'h0105, 16'h00FE, 4, 2,
                32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 8'h01, 8'h41, 8'h3F,
                32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 11, 1'b0, 1'b1};
    vecs[5] = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 16'h00A0, 16'h01A0, 16'h02A0, 1, 256,
                32'h76543210, 32'hFEDCBA98, 32'h00FF00FF, 8'h28, 8'h68, 8'hA8,
                32'h76543210, 32'hFEDCBA98, 32'h00FF00FF, 262, 1'b0, 1'b0};
    vecs[6] = '{32'h08080808, 32'h10101010, 32'h20202020, 16'h0020, 16'h0040, 16'h0080, 1, 257,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h08, 8'h10, 8'h20,
                32'h76543210, 32'hFEDCBA98, 32'h00FF00FF, 261, 1'b1, 1'b0};

    // Reset state
    @(negedge Clk); @(negedge Clk);
    chk("reset_status", 64'({Busy, Done, Err}), 64'(0));
    chk("reset_pulses", 64'({pe_start_sum, pe_start_bg, pe_ack}), 64'(0));
    chk("reset_exp", 64'({red_exp, green_exp, blue_exp}), 64'(0));
    chk("reset_out", 64'(red_out | green_out | blue_out), 64'(0));
    chk("reset_pe_in", 64'(pe_red_in | pe_green_in | pe_blue_in), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);

    // Table: watchdog, nominal, saturation, truncation, race, bg timeout
    for (int i = 0; i < 7; i++) do_frame(vecs[i], 1'b1);

    // Asynchronous reset during BG_WAIT
    red_in = vecs[5].r; green_in = vecs[5].g; blue_in = vecs[5].b;
    pe_red_sum = vecs[5].rs; pe_green_sum = vecs[5].gs; pe_blue_sum = vecs[5].bs;
    s_lat = vecs[5].s_lat; b_lat = vecs[5].b_lat;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    guard = 0;
    while (!pe_start_bg && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    chk("bg_req_reached", 64'(pe_start_bg), 64'(1));
    repeat (5) @(negedge Clk);
    chk("in_bg_wait_busy", 64'(Busy), 64'(1));
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_status", 64'({Busy, Done, Err}), 64'(0));
    chk("async_rst_pulses", 64'({pe_start_sum, pe_start_bg, pe_ack}), 64'(0));
    chk("async_rst_exp", 64'({red_exp, green_exp, blue_exp}), 64'(0));
    chk("async_rst_out", 64'(red_out | green_out | blue_out), 64'(0));
    chk("async_rst_pe_in", 64'(pe_red_in | pe_green_in | pe_blue_in), 64'(0));
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    do_frame(vecs[1], 1'b1);

    // Start together with Host_Ack in DONE: back to IDLE, Start is lost
    do_frame(vecs[3], 1'b0);
    Start = 1'b1; Host_Ack = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Host_Ack = 1'b0;
    chk("ack_start_idle", 64'({Busy, Done}), 64'(0));
    n_ss = 0;
    for (int k = 0; k < 4; k++) begin
      if (pe_start_sum || Busy) n_ss++;
      @(negedge Clk);
    end
    chk("lost_start_no_pass", 64'(n_ss), 64'(0));
    do_frame(vecs[2], 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL global_timeout: simulation did not complete (errors=%0d)", n_errors);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
